// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared definitions for the SPI bus arbiter.
//   INST_WRITE / INST_READ : accelerometer SPI instruction codes.
//   arb_state_e            : 3-bit arbiter FSM state encoding.
//   rr_next()              : round-robin pointer increment with wrap.
package spi_arb_pkg;

  localparam logic [7:0] INST_WRITE = 8'h0A;
  localparam logic [7:0] INST_READ  = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_GAP        = 3'd4
  } arb_state_e;

  // Next round-robin start index after granting 'id' among 'nreq' requesters.
  function automatic int rr_next(input int id, input int nreq);
    return (id + 1 >= nreq) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin requester selection for spi_bus_arbiter.
//   clk, rst_n     : clock, asynchronous active-low reset.
//   req_valid_i    : pending request per requester.
//   grant_en_i     : latch the current selection as the new grant.
//   advance_i      : move the start pointer to just past the current grant.
//   any_valid_o    : at least one request is pending.
//   sel_id_o       : combinational pick, first valid index at/after the pointer.
//   grant_id_o     : registered index of the current or last grant.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid_i,
  input  logic            grant_en_i,
  input  logic            advance_i,
  output logic            any_valid_o,
  output logic [IW-1:0]   sel_id_o,
  output logic [IW-1:0]   grant_id_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] sel;
  logic          found;

  // Index 'k' positions after 'base', wrapping at NREQ.
  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Rotate-and-priority-encode: scan from the pointer, first hit wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid_i[rot_idx(ptr_q, k)]) begin
        sel   = rot_idx(ptr_q, k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_d = grant_en_i ? sel : grant_q;
    ptr_d   = advance_i ? IW'(rr_next(int'(grant_q), NREQ)) : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign any_valid_o = |req_valid_i;
  assign sel_id_o    = sel;
  assign grant_id_o  = grant_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one SPI transmitter between NREQ requesters.
//   clk, rst                 : clock, asynchronous active-low reset.
//   req_valid/inst/rdh_wrl/addr/wdata : per-requester command (slice i).
//   req_ready                : one-cycle accept pulse to the granted requester.
//   rsp_valid/rsp_data/rsp_err : one-cycle completion pulse plus shared result.
//   grant_id, busy           : current/last grant index, FSM not in IDLE.
//   spi_ready/inst/rdh_wrl/addr/dout : command to the transmitter.
//   spi_din/din_valid/csn    : status from the transmitter.
//   dbg_state                : FSM state for observation.
//
// Handshake: a requester raises req_valid with stable fields and holds them
// until it sees req_ready high; the request is accepted in that cycle.
// rsp_valid is a one-cycle pulse with no back-pressure; rsp_data/rsp_err are
// meaningful only while rsp_valid is high.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int GAP_CYCLES = 255,
  parameter int TIMEOUT    = 4095
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_inst,
  input  logic [NREQ-1:0]          req_rdh_wrl,
  input  logic [8*NREQ-1:0]        req_addr,
  input  logic [8*NREQ-1:0]        req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [7:0]               rsp_data,
  output logic                     rsp_err,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     spi_ready,
  output logic [7:0]               spi_inst,
  output logic                     spi_rdh_wrl,
  output logic [7:0]               spi_addr,
  output logic [7:0]               spi_dout,
  input  logic [7:0]               spi_din,
  input  logic                     spi_din_valid,
  input  logic                     spi_csn,
  output logic [2:0]               dbg_state
);

  localparam int IW = $clog2(NREQ);

  arb_state_e state_q, state_d;

  logic [11:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;

  logic [7:0]  spi_inst_q, spi_inst_d;
  logic        spi_rdh_wrl_q, spi_rdh_wrl_d;
  logic [7:0]  spi_addr_q, spi_addr_d;
  logic [7:0]  spi_dout_q, spi_dout_d;

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            any_valid;
  logic [IW-1:0]   sel_id;
  logic [IW-1:0]   grant_q;
  logic [NREQ-1:0] grant_oh;
  logic            grant_en;
  logic            advance;
  logic            tmo_hit;
  logic            gap_done;
  logic            done_ok;
  logic            abort;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .clk         (clk),
    .rst_n       (rst),
    .req_valid_i (req_valid),
    .grant_en_i  (grant_en),
    .advance_i   (advance),
    .any_valid_o (any_valid),
    .sel_id_o    (sel_id),
    .grant_id_o  (grant_q)
  );

  assign grant_en = (state_q == ST_IDLE) && any_valid;
  assign advance  = (state_q == ST_ISSUE);
  // The counter holds the clocks already spent in the wait state, so this
  // fires on the TIMEOUT-th clock; >= keeps it sticky once saturated.
  assign tmo_hit  = int'(tmo_cnt_q) >= TIMEOUT - 1;
  assign gap_done = int'(gap_cnt_q) >= GAP_CYCLES - 1;

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    done_ok = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE:       if (any_valid) state_d = ST_ISSUE;
      ST_ISSUE:      state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (!spi_csn) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_WAIT_DONE: begin
        // Reads finish on din_valid (a coincident CSN rise is the same
        // completion); writes finish on CSN rising and ignore din_valid.
        if (spi_rdh_wrl_q ? spi_din_valid : spi_csn) begin
          done_ok = 1'b1;
          state_d = ST_GAP;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP:        if (gap_done) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Counters and datapath next values.
  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    spi_inst_d    = spi_inst_q;
    spi_rdh_wrl_d = spi_rdh_wrl_q;
    spi_addr_d    = spi_addr_q;
    spi_dout_d    = spi_dout_q;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;

    // Any state change clears the timeout counter, which covers entry to
    // both wait states.
    if (state_d != state_q)   tmo_cnt_d = '0;
    else if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 12'd1;

    if (state_q != ST_GAP)    gap_cnt_d = '0;
    else if (gap_cnt_q != '1) gap_cnt_d = gap_cnt_q + 16'd1;

    if (grant_en) begin
      spi_inst_d    = req_inst[8*int'(sel_id) +: 8];
      spi_rdh_wrl_d = req_rdh_wrl[sel_id];
      spi_addr_d    = req_addr[8*int'(sel_id) +: 8];
      spi_dout_d    = req_wdata[8*int'(sel_id) +: 8];
    end

    if (done_ok || abort) begin
      rsp_valid_d = grant_oh;
      rsp_data_d  = (done_ok && spi_rdh_wrl_q) ? spi_din : 8'h00;
      rsp_err_d   = abort;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      tmo_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      spi_inst_q    <= 8'h00;
      spi_rdh_wrl_q <= 1'b1;
      spi_addr_q    <= 8'h00;
      spi_dout_q    <= 8'h00;
      rsp_valid_q   <= '0;
      rsp_data_q    <= 8'h00;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      spi_inst_q    <= spi_inst_d;
      spi_rdh_wrl_q <= spi_rdh_wrl_d;
      spi_addr_q    <= spi_addr_d;
      spi_dout_q    <= spi_dout_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign spi_ready   = (state_q == ST_ISSUE);
  assign req_ready   = (state_q == ST_ISSUE) ? grant_oh : '0;
  assign busy        = (state_q != ST_IDLE);
  assign grant_id    = grant_q;
  assign spi_inst    = spi_inst_q;
  assign spi_rdh_wrl = spi_rdh_wrl_q;
  assign spi_addr    = spi_addr_q;
  assign spi_dout    = spi_dout_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: randomized scoreboard bench for spi_bus_arbiter.
// Requester drivers and a transmitter model stimulate the DUT; a monitor
// checks grants against a round-robin reference and responses against the
// per-requester expected queues.
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int GAP  = 255;
  localparam int TMO  = 4095;

  typedef struct packed {
    logic [7:0] inst;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_inst, req_addr, req_wdata;
  logic [NREQ-1:0]   req_rdh_wrl;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic [1:0]        grant_id;
  logic              busy, spi_ready, spi_rdh_wrl;
  logic [7:0]        spi_inst, spi_addr, spi_dout, spi_din;
  logic              spi_din_valid, spi_csn;
  logic [2:0]        dbg_state;

  spi_bus_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_inst(req_inst), .req_rdh_wrl(req_rdh_wrl),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .grant_id(grant_id), .busy(busy), .spi_ready(spi_ready),
    .spi_inst(spi_inst), .spi_rdh_wrl(spi_rdh_wrl), .spi_addr(spi_addr),
    .spi_dout(spi_dout), .spi_din(spi_din), .spi_din_valid(spi_din_valid),
    .spi_csn(spi_csn), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[NREQ][$];   // {err, data} per requester, in order
  req_t       pend_q[NREQ][$];  // head is the request currently presented
  int         grant_log[$];
  logic [7:0] mem [256];        // register contents returned on reads
  logic       tx_hang;          // transmitter never drops CSN
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.rw    = 1'($urandom_range(0, 1));
    r.inst  = r.rw ? INST_READ : INST_WRITE;
    r.addr  = 8'($urandom);
    r.wdata = 8'($urandom);
    return r;
  endfunction

  function automatic bit queues_empty();
    for (int i = 0; i < NREQ; i++)
      if (pend_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Issue a request and record the response the reference expects for it.
  task automatic submit(input int i, input req_t r);
    pend_q[i].push_back(r);
    if (tx_hang)   exp_q[i].push_back(9'h100);
    else if (r.rw) exp_q[i].push_back({1'b0, mem[r.addr]});
    else           exp_q[i].push_back(9'h000);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = queues_empty() && !busy && (req_valid == '0);
    end
    chk("drain_within_budget", 32'(done), 32'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    $display("reset value check: %s", tag);
    chk("rst_spi_ready",   32'(spi_ready),   32'd0);
    chk("rst_spi_rdh_wrl", 32'(spi_rdh_wrl), 32'd1);
    chk("rst_spi_inst",    32'(spi_inst),    32'd0);
    chk("rst_spi_addr",    32'(spi_addr),    32'd0);
    chk("rst_spi_dout",    32'(spi_dout),    32'd0);
    chk("rst_req_ready",   32'(req_ready),   32'd0);
    chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    chk("rst_rsp_data",    32'(rsp_data),    32'd0);
    chk("rst_rsp_err",     32'(rsp_err),     32'd0);
    chk("rst_grant_id",    32'(grant_id),    32'd0);
    chk("rst_busy",        32'(busy),        32'd0);
  endtask

  // ---------------- requester driver ----------------
  initial begin : req_driver
    logic [NREQ-1:0] acc;
    req_t r;
    req_valid = '0; req_inst = '0; req_rdh_wrl = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!rst) begin
          req_valid[i] = 1'b0;
        end else begin
          if (acc[i]) begin
            if (pend_q[i].size() > 0) void'(pend_q[i].pop_front());
            req_valid[i] = 1'b0;
          end
          if (!req_valid[i] && pend_q[i].size() > 0) begin
            r = pend_q[i][0];
            req_inst[8*i +: 8]  = r.inst;
            req_rdh_wrl[i]      = r.rw;
            req_addr[8*i +: 8]  = r.addr;
            req_wdata[8*i +: 8] = r.wdata;
            req_valid[i]        = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- transmitter model ----------------
  initial begin : tx_model
    int   tx_phase, tx_cnt;
    logic tx_start, tx_rw;
    logic [7:0] tx_addr;
    spi_csn = 1'b1; spi_din_valid = 1'b0; spi_din = 8'h00;
    tx_phase = 0; tx_cnt = 0; tx_rw = 1'b0; tx_addr = 8'h00;
    forever begin
      @(negedge clk);
      tx_start = spi_ready;
      @(posedge clk);
      #1;
      spi_din_valid = 1'b0;
      if (!rst) begin
        tx_phase = 0;
        spi_csn  = 1'b1;
      end else begin
        case (tx_phase)
          0: if (tx_start && !tx_hang) begin
               tx_rw    = spi_rdh_wrl;
               tx_addr  = spi_addr;
               tx_cnt   = $urandom_range(0, 3);
               tx_phase = 1;
             end
          1: if (tx_cnt == 0) begin
               spi_csn  = 1'b0;
               tx_cnt   = $urandom_range(2, 6);
               tx_phase = 2;
             end else tx_cnt--;
          2: if (tx_cnt == 0) begin
               if (tx_rw) begin
                 spi_din_valid = 1'b1;
                 spi_din       = mem[tx_addr];
                 if ($urandom_range(0, 1) == 1) begin
                   spi_csn  = 1'b1;
                   tx_phase = 0;
                 end else tx_phase = 3;
               end else begin
                 spi_csn  = 1'b1;
                 tx_phase = 0;
               end
             end else begin
               tx_cnt--;
               // Stray din_valid during a write must not complete it.
               if (!tx_rw && $urandom_range(0, 2) == 0) begin
                 spi_din_valid = 1'b1;
                 spi_din       = 8'($urandom);
               end
             end
          default: begin
               spi_csn  = 1'b1;
               tx_phase = 0;
             end
        endcase
      end
    end
  end

  // ---------------- monitor / checker ----------------
  initial begin : monitor
    int   model_ptr, last_grant, g, issue_cyc, rsp_cyc;
    bit   have_rsp, prev_ready, prev_idle_req, prev_dv, prev_csn, cur_rw;
    logic [NREQ-1:0] prev_valid;
    logic [8:0] e;
    req_t r;
    model_ptr = 0; last_grant = 0; issue_cyc = 0; rsp_cyc = 0; have_rsp = 0;
    prev_ready = 0; prev_idle_req = 0; prev_dv = 0; prev_csn = 1; cur_rw = 0;
    prev_valid = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        model_ptr = 0; have_rsp = 0; prev_ready = 0; prev_idle_req = 0;
        prev_valid = '0; prev_dv = 0; prev_csn = 1;
        continue;
      end

      if (prev_idle_req) chk("grant_latency", 32'(spi_ready), 32'd1);

      if (spi_ready) begin
        g = rr_pick(model_ptr, prev_valid);
        chk("spi_ready_one_cycle", 32'(prev_ready), 32'd0);
        chk("grant_id", 32'(grant_id), 32'(g));
        chk("req_ready_onehot", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("busy_in_issue", 32'(busy), 32'd1);
        if (g >= 0) begin
          chk("granted_has_request", 32'(pend_q[g].size() > 0), 32'd1);
          if (pend_q[g].size() > 0) begin
            r = pend_q[g][0];
            chk("spi_inst",    32'(spi_inst),    32'(r.inst));
            chk("spi_rdh_wrl", 32'(spi_rdh_wrl), 32'(r.rw));
            chk("spi_addr",    32'(spi_addr),    32'(r.addr));
            chk("spi_dout",    32'(spi_dout),    32'(r.wdata));
            cur_rw = r.rw;
          end
          model_ptr  = (g + 1) % NREQ;
          last_grant = g;
          grant_log.push_back(g);
        end
        issue_cyc = cyc;
      end else begin
        chk("req_ready_quiet", 32'(req_ready), 32'd0);
      end

      if (rsp_valid != '0) begin
        chk("rsp_index", 32'(rsp_valid), 32'd1 << last_grant);
        chk("rsp_was_expected", 32'(exp_q[last_grant].size() > 0), 32'd1);
        if (exp_q[last_grant].size() > 0) begin
          e = exp_q[last_grant].pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e[7:0]));
          chk("rsp_err",  32'(rsp_err),  32'(e[8]));
          if (e[8]) chk("timeout_latency", 32'(cyc - issue_cyc), 32'(TMO + 1));
          else      chk("rsp_latency", 32'(cur_rw ? prev_dv : prev_csn), 32'd1);
        end
        have_rsp = 1;
        rsp_cyc  = cyc;
      end

      // The idle gap starts in the response cycle and lasts exactly GAP clocks.
      if (have_rsp && cyc == rsp_cyc + GAP - 1) chk("busy_through_gap", 32'(busy), 32'd1);
      if (have_rsp && cyc == rsp_cyc + GAP)     chk("idle_after_gap",   32'(busy), 32'd0);

      prev_idle_req = !busy && (req_valid != '0);
      prev_valid    = req_valid;
      prev_ready    = spi_ready;
      prev_dv       = spi_din_valid;
      prev_csn      = spi_csn;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin : main
    req_t r;
    int   w;
    rst = 1'b0;
    tx_hang = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    mem[8'h08] = 8'h5A;

    repeat (3) @(negedge clk);
    check_reset_values("power-on");
    @(posedge clk);
    #2;
    rst = 1'b1;
    cycles(2);

    // Single read from requester 1.
    r = '{inst: INST_READ, rw: 1'b1, addr: 8'h08, wdata: 8'h00};
    submit(1, r);
    wait_drain(2000);

    // Single write from requester 0.
    r = '{inst: INST_WRITE, rw: 1'b0, addr: 8'h2D, wdata: 8'h0A};
    submit(0, r);
    wait_drain(2000);

    // Randomized mix with bursts and idle stretches.
    for (int k = 0; k < 24; k++) begin
      submit($urandom_range(0, NREQ - 1), rand_req());
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 400));
    end
    wait_drain(30000);

    // Timeout: transmitter never starts, then normal service resumes.
    tx_hang = 1'b1;
    r = rand_req();
    r.rw = 1'b1;
    r.inst = INST_READ;
    submit(2, r);
    wait_drain(TMO + 1000);
    tx_hang = 1'b0;
    submit(2, rand_req());
    wait_drain(2000);

    // Reset during WAIT_DONE of a requester-1 read.
    r = rand_req();
    r.rw = 1'b1;
    r.inst = INST_READ;
    submit(1, r);
    w = 0;
    while (spi_csn !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("csn_low_before_reset", 32'(spi_csn), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend_q[i].delete();
      exp_q[i].delete();
    end
    grant_log.delete();
    @(negedge clk);
    check_reset_values("mid-transaction");
    cycles(3);
    rst = 1'b1;
    cycles(2);

    // All requesters held valid: grants must rotate from requester 0.
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < NREQ; i++) submit(i, rand_req());
    wait_drain(5000);
    chk("rr_count", 32'(grant_log.size()), 32'd6);
    for (int k = 0; k < grant_log.size() && k < 6; k++)
      chk("rr_order", 32'(grant_log[k]), 32'(k % NREQ));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
